// File: rtl/wt_dcache_port_sched.sv
// Schedules NR_PORTS requesters (port 0 = PTW) onto a single registered cache request slot
// and routes in-order responses back to their owner. Optional macro: WT_DCACHE_SCHED_PTW_PRIO_EN.
module wt_dcache_port_sched #(
  parameter int unsigned NR_PORTS        = 3,
  parameter int unsigned ADDR_WIDTH      = 64,
  parameter int unsigned DATA_WIDTH      = 64,
  parameter int unsigned MAX_OUTSTANDING = 7
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [NR_PORTS-1:0]            req_valid_i,
  output logic [NR_PORTS-1:0]            req_ready_o,
  input  logic [NR_PORTS*ADDR_WIDTH-1:0] req_addr_i,
  input  logic [NR_PORTS-1:0]            req_we_i,
  input  logic [NR_PORTS*DATA_WIDTH-1:0] req_wdata_i,
  output logic                           mem_req_valid_o,
  input  logic                           mem_req_ready_i,
  output logic [ADDR_WIDTH-1:0]          mem_req_addr_o,
  output logic                           mem_req_we_o,
  output logic [DATA_WIDTH-1:0]          mem_req_wdata_o,
  input  logic                           mem_rsp_valid_i,
  input  logic [DATA_WIDTH-1:0]          mem_rsp_rdata_i,
  output logic [NR_PORTS-1:0]            rsp_valid_o,
  output logic [DATA_WIDTH-1:0]          rsp_rdata_o,
  output logic                           busy_o
);

  localparam int unsigned PW = (NR_PORTS > 1) ? $clog2(NR_PORTS) : 1;
  localparam int unsigned FW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);

  logic [ADDR_WIDTH-1:0] port_addr  [NR_PORTS];
  logic [DATA_WIDTH-1:0] port_wdata [NR_PORTS];

  logic [PW-1:0] rr_ptr_q;
  logic [PW-1:0] gnt_idx;
  logic [PW-1:0] cand;
  logic          gnt_found;
  logic          gnt_prio;
  logic          slot_free;
  logic          accept;
  logic          rsp_fire;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic [FW-1:0] wr_ptr_q;
  logic [FW-1:0] rd_ptr_q;
  logic [PW-1:0] fifo_q [MAX_OUTSTANDING];
  logic          busy_q;

  for (genvar g = 0; g < NR_PORTS; g++) begin : g_unpack
    assign port_addr[g]  = req_addr_i[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign port_wdata[g] = req_wdata_i[g*DATA_WIDTH +: DATA_WIDTH];
  end

  function automatic logic [FW-1:0] ptr_inc(input logic [FW-1:0] p);
    return (p == FW'(MAX_OUTSTANDING - 1)) ? '0 : p + FW'(1);
  endfunction

  // Grant search: optional fixed PTW priority, otherwise round-robin from rr_ptr+1
  always_comb begin
    gnt_idx   = '0;
    gnt_found = 1'b0;
    gnt_prio  = 1'b0;
    cand      = '0;
`ifdef WT_DCACHE_SCHED_PTW_PRIO_EN
    if (req_valid_i[0]) begin
      gnt_found = 1'b1;
      gnt_prio  = 1'b1;
    end
`endif
    for (int unsigned i = 1; i <= NR_PORTS; i++) begin
      cand = PW'((32'(rr_ptr_q) + i) % NR_PORTS);
      if (!gnt_found && req_valid_i[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  // The order FIFO holds exactly cnt entries, so cnt doubles as its fill level
  assign slot_free = !mem_req_valid_o || mem_req_ready_i;
  assign accept    = !rst_i && slot_free && (cnt_q < CW'(MAX_OUTSTANDING)) && gnt_found;
  assign rsp_fire  = !rst_i && mem_rsp_valid_i && (cnt_q != '0);

  assign req_ready_o = accept ? (NR_PORTS'(1) << gnt_idx) : '0;
  assign rsp_rdata_o = mem_rsp_rdata_i;
  assign busy_o      = busy_q;

  always_comb begin
    rsp_valid_o = '0;
    for (int unsigned k = 0; k < NR_PORTS; k++) begin
      rsp_valid_o[k] = rsp_fire && (fifo_q[rd_ptr_q] == PW'(k));
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (accept && !rsp_fire) begin
      cnt_d = cnt_q + CW'(1);
    end else if (!accept && rsp_fire) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  // Output slot, counters and pointers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mem_req_valid_o <= 1'b0;
      mem_req_addr_o  <= '0;
      mem_req_we_o    <= 1'b0;
      mem_req_wdata_o <= '0;
      cnt_q           <= '0;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      rr_ptr_q        <= PW'(NR_PORTS - 1);
      busy_q          <= 1'b0;
    end else begin
      if (accept) begin
        mem_req_valid_o <= 1'b1;
        mem_req_addr_o  <= port_addr[gnt_idx];
        mem_req_we_o    <= req_we_i[gnt_idx];
        mem_req_wdata_o <= port_wdata[gnt_idx];
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end else if (mem_req_ready_i) begin
        mem_req_valid_o <= 1'b0;
      end
      if (accept && !gnt_prio) begin
        rr_ptr_q <= gnt_idx;
      end
      if (rsp_fire) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      cnt_q  <= cnt_d;
      busy_q <= (cnt_d != '0);
    end
  end

  // Owner storage needs no reset; pointers and cnt define validity
  always_ff @(posedge clk_i) begin
    if (accept) begin
      fifo_q[wr_ptr_q] <= gnt_idx;
    end
  end

endmodule

// File: tb/tb_wt_dcache_port_sched.sv
// Scoreboard bench for wt_dcache_port_sched: grant owners are queued on accept and
// popped when the response is routed.
module tb_wt_dcache_port_sched;

  localparam int NP = 3;
  localparam int AW = 64;
  localparam int DW = 64;
  localparam int MO = 7;

  logic             clk = 1'b0;
  logic             rst;
  logic [NP-1:0]    req_valid, req_ready, req_we, rsp_valid;
  logic [NP*AW-1:0] req_addr;
  logic [NP*DW-1:0] req_wdata;
  logic             mem_req_valid, mem_req_ready, mem_req_we, mem_rsp_valid, busy;
  logic [AW-1:0]    mem_req_addr;
  logic [DW-1:0]    mem_req_wdata, mem_rsp_rdata, rsp_rdata;

  int vectors;
  int miscompares;
  int owners[$];
  int m_rr;

  wt_dcache_port_sched #(
    .NR_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(MO)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_addr_i(req_addr),
    .req_we_i(req_we), .req_wdata_i(req_wdata),
    .mem_req_valid_o(mem_req_valid), .mem_req_ready_i(mem_req_ready),
    .mem_req_addr_o(mem_req_addr), .mem_req_we_o(mem_req_we), .mem_req_wdata_o(mem_req_wdata),
    .mem_rsp_valid_i(mem_rsp_valid), .mem_rsp_rdata_i(mem_rsp_rdata),
    .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata), .busy_o(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  function automatic logic [NP-1:0] oh(input int g);
    return (g < 0) ? '0 : (NP'(1) << g);
  endfunction

  function automatic int pick(input logic [NP-1:0] v);
`ifdef WT_DCACHE_SCHED_PTW_PRIO_EN
    if (v[0]) return 0;
`endif
    for (int i = 1; i <= NP; i++) begin
      if (v[(m_rr + i) % NP]) return (m_rr + i) % NP;
    end
    return -1;
  endfunction

  // Reference arbiter step; port-0 priority grants leave the pointer alone
  task automatic model_grant(input logic [NP-1:0] v, output int g);
    g = pick(v);
`ifdef WT_DCACHE_SCHED_PTW_PRIO_EN
    if (g > 0) m_rr = g;
`else
    if (g >= 0) m_rr = g;
`endif
  endtask

  task automatic set_port(input int k, input logic [AW-1:0] a, input logic we, input logic [DW-1:0] d);
    req_addr[k*AW +: AW]  = a;
    req_we[k]             = we;
    req_wdata[k*DW +: DW] = d;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = '1; mem_req_ready = 1'b1; mem_rsp_valid = 1'b1;
    @(posedge clk); #2;
    vectors++;
    if (mem_req_valid !== 1'b0 || mem_req_addr !== '0 || mem_req_we !== 1'b0 || mem_req_wdata !== '0) begin
      miscompares++;
      $display("FAIL reset_slot got v=%b a=%h we=%b d=%h want all zero", mem_req_valid, mem_req_addr, mem_req_we, mem_req_wdata);
    end
    vectors++;
    if (req_ready !== '0) begin miscompares++; $display("FAIL reset_req_ready got %b want 000", req_ready); end
    vectors++;
    if (rsp_valid !== '0) begin miscompares++; $display("FAIL reset_rsp_valid got %b want 000", rsp_valid); end
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", busy); end
    @(posedge clk); #1;
    rst = 1'b0; req_valid = '0; mem_rsp_valid = 1'b0;
    m_rr = NP - 1;
    owners.delete();
  endtask

  task automatic test_round_robin();
    bit rsp_at [0:31];
    int exp_g;
    logic [NP-1:0] e;
    mem_req_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      req_valid     = (c < 6) ? '1 : '0;
      mem_rsp_valid = rsp_at[c];
      mem_rsp_rdata = 64'hD000 + 64'(c);
      @(negedge clk);
      exp_g = (c < 6) ? c % 3 : -1;
      e = oh(exp_g);
      vectors++;
      if (req_ready !== e) begin miscompares++; $display("FAIL rr_grant c=%0d got %b want %b", c, req_ready, e); end
      if (mem_rsp_valid) begin
        e = '0;
        if (owners.size() > 0) e = oh(owners.pop_front());
        vectors++;
        if (rsp_valid !== e || rsp_rdata !== 64'hD000 + 64'(c)) begin
          miscompares++;
          $display("FAIL rr_rsp c=%0d got %b/%h want %b/%h", c, rsp_valid, rsp_rdata, e, 64'hD000 + 64'(c));
        end
      end
      if (exp_g >= 0) begin
        owners.push_back(exp_g);
        rsp_at[c+3] = 1'b1;
        m_rr = exp_g;
      end
      if (c >= 1 && c <= 6) begin
        vectors++;
        if (mem_req_valid !== 1'b1 || mem_req_addr !== 64'h1000 * 64'((c - 1) % 3 + 1)) begin
          miscompares++;
          $display("FAIL rr_slot c=%0d got v=%b a=%h want v=1 a=%h", c, mem_req_valid, mem_req_addr, 64'h1000 * 64'((c - 1) % 3 + 1));
        end
      end
    end
  endtask

  task automatic test_stall();
    int g;
    logic [NP-1:0] e;
    @(posedge clk); #1;
    set_port(1, 64'h8000_1000, 1'b1, 64'hCAFE);
    req_valid = 3'b010; mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
    @(negedge clk);
    model_grant(req_valid, g); e = oh(g);
    vectors++;
    if (req_ready !== e) begin miscompares++; $display("FAIL stall_first_grant got %b want %b", req_ready, e); end
    owners.push_back(g);
    for (int c = 1; c <= 5; c++) begin
      @(posedge clk); #1;
      set_port(1, 64'h8000_2000, 1'b0, 64'h0);
      @(negedge clk);
      vectors++;
      if (req_ready !== '0 || mem_req_valid !== 1'b1 || mem_req_addr !== 64'h8000_1000 ||
          mem_req_we !== 1'b1 || mem_req_wdata !== 64'hCAFE) begin
        miscompares++;
        $display("FAIL stall_hold c=%0d got rdy=%b v=%b a=%h we=%b d=%h want rdy=000 v=1 a=80001000 we=1 d=cafe",
                 c, req_ready, mem_req_valid, mem_req_addr, mem_req_we, mem_req_wdata);
      end
    end
    @(posedge clk); #1;
    mem_req_ready = 1'b1;
    @(negedge clk);
    model_grant(req_valid, g); e = oh(g);
    vectors++;
    if (req_ready !== e) begin miscompares++; $display("FAIL stall_release_grant got %b want %b", req_ready, e); end
    owners.push_back(g);
    @(posedge clk); #1;
    req_valid = '0;
    @(negedge clk);
    vectors++;
    if (mem_req_valid !== 1'b1 || mem_req_addr !== 64'h8000_2000 || mem_req_we !== 1'b0) begin
      miscompares++;
      $display("FAIL stall_next_slot got v=%b a=%h we=%b want v=1 a=80002000 we=0", mem_req_valid, mem_req_addr, mem_req_we);
    end
    @(posedge clk); #1;
    @(negedge clk);
    vectors++;
    if (mem_req_valid !== 1'b0 || busy !== 1'b1) begin
      miscompares++; $display("FAIL stall_drained got v=%b busy=%b want v=0 busy=1", mem_req_valid, busy);
    end
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      mem_rsp_valid = 1'b1;
      @(negedge clk);
      e = '0;
      if (owners.size() > 0) e = oh(owners.pop_front());
      vectors++;
      if (rsp_valid !== e) begin miscompares++; $display("FAIL stall_rsp c=%0d got %b want %b", c, rsp_valid, e); end
    end
    @(posedge clk); #1;
    mem_rsp_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL stall_idle_busy got %b want 0", busy); end
  endtask

  task automatic test_max_outstanding();
    int g, acc;
    logic [NP-1:0] e;
    acc = 0; mem_req_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      req_valid = '1; mem_rsp_valid = 1'b0;
      @(negedge clk);
      g = -1;
      if (c < MO) model_grant(req_valid, g);
      e = oh(g);
      vectors++;
      if (req_ready !== e) begin miscompares++; $display("FAIL max_grant c=%0d got %b want %b", c, req_ready, e); end
      if (g >= 0) owners.push_back(g);
      acc += $countones(req_ready);
    end
    vectors++;
    if (acc !== MO || busy !== 1'b1) begin
      miscompares++; $display("FAIL max_accepts got %0d busy=%b want %0d busy=1", acc, busy, MO);
    end
    @(posedge clk); #1;
    mem_rsp_valid = 1'b1; mem_rsp_rdata = 64'h5A5A;
    @(negedge clk);
    vectors++;
    if (req_ready !== '0) begin miscompares++; $display("FAIL max_full_same_cycle got %b want 000", req_ready); end
    e = '0;
    if (owners.size() > 0) e = oh(owners.pop_front());
    vectors++;
    if (rsp_valid !== e) begin miscompares++; $display("FAIL max_rsp got %b want %b", rsp_valid, e); end
    acc = 0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      mem_rsp_valid = 1'b0;
      @(negedge clk);
      g = -1;
      if (c == 0) model_grant(req_valid, g);
      e = oh(g);
      vectors++;
      if (req_ready !== e) begin miscompares++; $display("FAIL max_refill c=%0d got %b want %b", c, req_ready, e); end
      if (g >= 0) owners.push_back(g);
      acc += $countones(req_ready);
    end
    vectors++;
    if (acc !== 1 || busy !== 1'b1) begin
      miscompares++; $display("FAIL max_refill_count got %0d busy=%b want 1 busy=1", acc, busy);
    end
    for (int c = 0; c < MO; c++) begin
      @(posedge clk); #1;
      req_valid = '0; mem_rsp_valid = 1'b1;
      @(negedge clk);
      e = '0;
      if (owners.size() > 0) e = oh(owners.pop_front());
      vectors++;
      if (rsp_valid !== e) begin miscompares++; $display("FAIL max_drain c=%0d got %b want %b", c, rsp_valid, e); end
    end
    @(posedge clk); #1;
    mem_rsp_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL max_drained_busy got %b want 0", busy); end
  endtask

  task automatic test_same_cycle();
    int g;
    logic [NP-1:0] e;
    mem_req_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      req_valid = 3'b001; mem_rsp_valid = 1'b0;
      @(negedge clk);
      model_grant(req_valid, g); e = oh(g);
      vectors++;
      if (req_ready !== e) begin miscompares++; $display("FAIL same_fill c=%0d got %b want %b", c, req_ready, e); end
      owners.push_back(g);
    end
    @(posedge clk); #1;
    req_valid = 3'b100; mem_rsp_valid = 1'b1;
    @(negedge clk);
    model_grant(req_valid, g); e = oh(g);
    vectors++;
    if (req_ready !== e) begin miscompares++; $display("FAIL same_grant got %b want %b", req_ready, e); end
    e = '0;
    if (owners.size() > 0) e = oh(owners.pop_front());
    vectors++;
    if (rsp_valid !== e) begin miscompares++; $display("FAIL same_rsp_oldest got %b want %b", rsp_valid, e); end
    owners.push_back(g);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      req_valid = '0; mem_rsp_valid = 1'b1;
      @(negedge clk);
      if (c == 2) begin
        vectors++;
        if (busy !== 1'b1) begin miscompares++; $display("FAIL same_cnt_one got busy=%b want 1", busy); end
      end
      e = '0;
      if (owners.size() > 0) e = oh(owners.pop_front());
      vectors++;
      if (rsp_valid !== e) begin miscompares++; $display("FAIL same_drain c=%0d got %b want %b", c, rsp_valid, e); end
    end
    @(posedge clk); #1;
    mem_rsp_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL same_cnt_zero got busy=%b want 0", busy); end
  endtask

  task automatic test_reset_mid();
    int g;
    logic [NP-1:0] e;
    mem_req_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      req_valid = 3'b010; mem_rsp_valid = 1'b0;
      @(negedge clk);
      model_grant(req_valid, g); e = oh(g);
      vectors++;
      if (req_ready !== e) begin miscompares++; $display("FAIL mid_fill c=%0d got %b want %b", c, req_ready, e); end
    end
    @(posedge clk); #1;
    mem_req_ready = 1'b0;
    vectors++;
    if (mem_req_valid !== 1'b1 || busy !== 1'b1) begin
      miscompares++; $display("FAIL mid_loaded got v=%b busy=%b want v=1 busy=1", mem_req_valid, busy);
    end
    #2;
    rst = 1'b1; mem_rsp_valid = 1'b1;
    #1;
    vectors++;
    if (mem_req_valid !== 1'b0 || mem_req_addr !== '0 || mem_req_we !== 1'b0 || mem_req_wdata !== '0 ||
        busy !== 1'b0 || req_ready !== '0 || rsp_valid !== '0) begin
      miscompares++;
      $display("FAIL mid_async_reset got v=%b a=%h busy=%b rdy=%b rsp=%b want all zero",
               mem_req_valid, mem_req_addr, busy, req_ready, rsp_valid);
    end
    @(posedge clk); #1;
    rst = 1'b0; req_valid = '0; mem_req_ready = 1'b1; mem_rsp_valid = 1'b1;
    owners.delete();
    m_rr = NP - 1;
    @(negedge clk);
    vectors++;
    if (rsp_valid !== '0) begin miscompares++; $display("FAIL mid_stray_rsp got %b want 000", rsp_valid); end
    @(posedge clk); #1;
    mem_rsp_valid = 1'b0; req_valid = '1;
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL mid_stray_cnt got busy=%b want 0", busy); end
    model_grant(req_valid, g); e = oh(g);
    vectors++;
    if (req_ready !== e) begin miscompares++; $display("FAIL mid_regrant got %b want %b", req_ready, e); end
    owners.push_back(g);
    @(posedge clk); #1;
    req_valid = '0; mem_rsp_valid = 1'b1;
    @(negedge clk);
    e = '0;
    if (owners.size() > 0) e = oh(owners.pop_front());
    vectors++;
    if (rsp_valid !== e) begin miscompares++; $display("FAIL mid_rsp got %b want %b", rsp_valid, e); end
    @(posedge clk); #1;
    mem_rsp_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL mid_final_busy got %b want 0", busy); end
  endtask

`ifdef WT_DCACHE_SCHED_PTW_PRIO_EN
  task automatic test_ptw_prio();
    int g;
    logic [NP-1:0] e;
    mem_req_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      req_valid = (c < 4) ? 3'b101 : 3'b100; mem_rsp_valid = 1'b0;
      @(negedge clk);
      model_grant(req_valid, g); e = oh(g);
      vectors++;
      if (req_ready !== e) begin miscompares++; $display("FAIL prio_grant c=%0d got %b want %b", c, req_ready, e); end
      owners.push_back(g);
    end
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      req_valid = '0; mem_rsp_valid = 1'b1;
      @(negedge clk);
      e = '0;
      if (owners.size() > 0) e = oh(owners.pop_front());
      vectors++;
      if (rsp_valid !== e) begin miscompares++; $display("FAIL prio_rsp c=%0d got %b want %b", c, rsp_valid, e); end
    end
    @(posedge clk); #1;
    mem_rsp_valid = 1'b0;
  endtask
`endif

  initial begin
    rst = 1'b1; req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    mem_req_ready = 1'b1; mem_rsp_valid = 1'b0; mem_rsp_rdata = '0;
    vectors = 0; miscompares = 0; m_rr = NP - 1;
    for (int k = 0; k < NP; k++) set_port(k, 64'h1000 * 64'(k + 1), 1'b0, 64'h0);
    test_reset();
`ifdef WT_DCACHE_SCHED_PTW_PRIO_EN
    test_ptw_prio();
`else
    test_round_robin();
`endif
    test_stall();
    test_max_outstanding();
    test_same_cycle();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/wt_dcache_port_sched.md
WT_DCACHE_PORT_SCHED -- requirements
Module: wt_dcache_port_sched

Interface
REQ-001 Parameter NR_PORTS, default 3: number of requesters; port 0 is the PTW.
REQ-002 Parameter ADDR_WIDTH, default 64: request address width.
REQ-003 Parameter DATA_WIDTH, default 64: data width.
REQ-004 Parameter MAX_OUTSTANDING, default 7: maximum issued-but-unanswered requests; range 1..15.
REQ-005 The block SHALL have one clock, clk_i, and an asynchronous active-high reset, rst_i.
REQ-006 Ports SHALL be as follows:
- clk_i, in, 1: clock; rising edge.
- rst_i, in, 1: asynchronous active-high reset.
- req_valid_i, in, NR_PORTS: per-port request valid.
- req_ready_o, out, NR_PORTS: per-port accept; one-hot or zero.
- req_addr_i, in, NR_PORTS*ADDR_WIDTH: per-port address, port k at slice k.
- req_we_i, in, NR_PORTS: per-port write enable.
- req_wdata_i, in, NR_PORTS*DATA_WIDTH: per-port write data.
- mem_req_valid_o, out, 1: registered request to the cache.
- mem_req_ready_i, in, 1: cache accept.
- mem_req_addr_o, out, ADDR_WIDTH: registered address.
- mem_req_we_o, out, 1: registered write enable.
- mem_req_wdata_o, out, DATA_WIDTH: registered write data.
- mem_rsp_valid_i, in, 1: in-order response/ack for reads and writes.
- mem_rsp_rdata_i, in, DATA_WIDTH: response data.
- rsp_valid_o, out, NR_PORTS: response routed to its owner; one-hot or zero.
- rsp_rdata_o, out, DATA_WIDTH: equals mem_rsp_rdata_i.
- busy_o, out, 1: outstanding count is nonzero.

Function
REQ-007 Output slot: a one-entry register drives the mem_req_* outputs. A transfer occurs when mem_req_valid_o and mem_req_ready_i are both high.
REQ-008 Slot stability: while mem_req_valid_o is high and mem_req_ready_i is low, the mem_req_* outputs SHALL hold their values.
REQ-009 Accept condition: a new grant is allowed when the slot is empty or transfers in the same cycle, and when cnt < MAX_OUTSTANDING.
- cnt counts requests in the slot plus issued-but-unanswered requests.
REQ-010 Grant: exactly one valid port is granted per accept.
- The granted port sees req_ready_o high for that cycle only.
- Its request is loaded into the slot, giving a 1-cycle request latency.
REQ-011 Round-robin: the search starts at rr_ptr+1 and wraps modulo NR_PORTS.
- rr_ptr updates to the granted index only on accept.
REQ-012 Order FIFO: on accept, the granted port index is pushed into an in-order FIFO of depth MAX_OUTSTANDING.
REQ-013 Response routing: when mem_rsp_valid_i is high and the FIFO is non-empty:
- rsp_valid_o is one-hot at the head index in the same cycle (combinational).
- The FIFO head is popped.
REQ-014 A response arriving with an empty FIFO SHALL be dropped; rsp_valid_o stays 0 and the state is unchanged.
REQ-015 cnt update: +1 on accept, -1 on a routed response.
- Accept and response in the same cycle leave cnt unchanged.
- cnt never exceeds MAX_OUTSTANDING or goes below 0.
REQ-016 At cnt == MAX_OUTSTANDING, req_ready_o SHALL be all-zero. An accept is allowed in the same cycle a response frees a slot only if cnt was below the maximum at the start of that cycle.
REQ-017 FIFO pointers SHALL wrap at MAX_OUTSTANDING. Push and pop in the same cycle on a full FIFO cannot occur, because of REQ-016.

Reset
REQ-018 On rst_i high, asynchronously:
- mem_req_valid_o = 0 and the other mem_req_* outputs = 0.
- cnt = 0, FIFO empty, rr_ptr = NR_PORTS-1 (so port 0 is searched first).
- busy_o = 0.
REQ-019 Reset asserted mid-transaction SHALL discard the slot and FIFO contents. Responses arriving after reset are dropped per REQ-014.
REQ-020 While rst_i is high, req_ready_o and rsp_valid_o SHALL be 0.

Configuration
REQ-021 Macro WT_DCACHE_SCHED_PTW_PRIO_EN:
- Defined: port 0, when valid, wins every grant regardless of rr_ptr, and rr_ptr is not updated by port-0 grants. The remaining ports use round-robin.
- Undefined: pure round-robin over all ports per REQ-011.

Verification
REQ-022 All 3 ports valid continuously, mem_req_ready_i=1, responses 2 cycles later, macro undefined -> grants 0,1,2,0,1,2; each rsp_valid_o one-hot matches its owner in order.
REQ-023 mem_req_ready_i=0 for 5 cycles with slot loaded at addr 0x8000_1000 -> mem_req_* outputs held stable; no further req_ready_o; on ready, transfer occurs and the next grant follows.
REQ-024 No responses, continuous requests -> exactly 7 accepts, then req_ready_o=0 and busy_o=1; one response -> exactly one further accept, and cnt stays at 7.
REQ-025 cnt=3, accept and response in the same cycle -> cnt remains 3; the response is routed to the oldest FIFO entry.
REQ-026 Macro defined, ports 0 and 2 always valid -> port 0 granted every accept, port 2 starved; port 0 deasserted -> port 2 granted next cycle.
REQ-027 rst_i pulsed with 4 outstanding -> all outputs 0 asynchronously; a stray mem_rsp_valid_i afterwards yields rsp_valid_o=0 and cnt=0.
